// File: rtl/jtagdebug_host_pkg.sv
// Shared definitions for the JTAG debug host: FSM encoding, word width and
// the target's debug register map.
package jtagdebug_host_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CAP  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        EXIT = 3'd4
    } state_t;

    localparam logic [WORD_W-1:0] REG_STATUS = 16'hff00;
    localparam logic [WORD_W-1:0] REG_ARM    = 16'hff01;
    localparam logic [WORD_W-1:0] REG_WIDTH  = 16'hff02;
    localparam logic [WORD_W-1:0] REG_DEPTH  = 16'hff03;

endpackage

// File: rtl/jtagdebug_host_div.sv
// drck generator: DIV cycles low then DIV cycles high per bit; rise/fall flag the
// edge that drives drck high/low. hold freezes the low phase; drck idles low.
module jtagdebug_host_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic hold,
    output logic drck,
    output logic fall,
    output logic rise
);

    logic [7:0] cnt;
    logic       phase_end;

    assign phase_end = (cnt == 8'(DIV - 1));
    assign rise      = run && !drck && phase_end && !hold;
    assign fall      = run && drck && phase_end;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt  <= 8'd0;
            drck <= 1'b0;
        end else if (phase_end && (drck || !hold)) begin
            cnt  <= 8'd0;
            drck <= !drck;
        end else if (drck || !hold) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/jtagdebug_host.sv
// JTAG debug host: CAP, 16 address bits, len data words, EXIT; one word out per 16 tdo bits.
// A pending unaccepted word stalls the next word's first bit with drck held low.
module jtagdebug_host
    import jtagdebug_host_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WORD_W-1:0] cmd_addr,
    input  logic [WORD_W-1:0] cmd_len,
    input  logic [WORD_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic              busy,
    output logic              drck,
    output logic              capture,
    output logic              shift,
    output logic              tdi,
    input  logic              tdo
);

    state_t            state, state_nx;
    logic [3:0]        bit_cnt;
    logic [WORD_W-1:0] word_cnt;
    logic [WORD_W-1:0] len_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] tx_sr;
    logic [WORD_W-2:0] rx_sr;
    logic              exit_done;
    logic              run, hold, fall, rise;
    logic              pending, last_bit, last_word;

    assign pending   = rsp_valid && !rsp_ready;
    assign last_bit  = (bit_cnt == 4'hf);
    assign last_word = (word_cnt == len_q - 16'd1);
    assign run       = (state != IDLE) && !exit_done;
    assign hold      = (state == DATA) && (bit_cnt == 4'd0) && (word_cnt != 16'd0) && pending;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    jtagdebug_host_div #(.DIV(DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .hold (hold),
        .drck (drck),
        .fall (fall),
        .rise (rise)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (cmd_valid) state_nx = CAP;
            CAP:  if (fall) state_nx = ADDR;
            ADDR: if (fall && last_bit) state_nx = (len_q == 16'd0) ? EXIT : DATA;
            DATA: if (fall && last_bit && last_word) state_nx = EXIT;
            // Never return to IDLE with a captured word still unaccepted.
            EXIT: if ((fall || exit_done) && !pending) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= 4'd0;
            word_cnt  <= 16'd0;
            len_q     <= 16'd0;
            wdata_q   <= 16'd0;
            tx_sr     <= 16'd0;
            rx_sr     <= 15'd0;
            exit_done <= 1'b0;
            capture   <= 1'b0;
            shift     <= 1'b0;
            tdi       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 16'd0;
        end else begin
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    len_q     <= cmd_len;
                    wdata_q   <= cmd_wdata;
                    tx_sr     <= cmd_addr;
                    bit_cnt   <= 4'd0;
                    word_cnt  <= 16'd0;
                    exit_done <= 1'b0;
                    capture   <= 1'b1;
                    shift     <= 1'b0;
                    tdi       <= 1'b0;
                end
                CAP: if (fall) begin
                    capture <= 1'b0;
                    shift   <= 1'b1;
                    tdi     <= tx_sr[15];
                    tx_sr   <= {tx_sr[14:0], 1'b0};
                end
                ADDR: if (fall) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (last_bit && len_q == 16'd0) begin
                        shift <= 1'b0;
                        tdi   <= 1'b0;
                    end else if (last_bit) begin
                        tdi   <= wdata_q[15];
                        tx_sr <= {wdata_q[14:0], 1'b0};
                    end else begin
                        tdi   <= tx_sr[15];
                        tx_sr <= {tx_sr[14:0], 1'b0};
                    end
                end
                DATA: begin
                    // tdo is taken before the target sees this drck edge.
                    if (rise) begin
                        rx_sr <= {rx_sr[13:0], tdo};
                        if (last_bit) begin
                            rsp_data  <= {rx_sr, tdo};
                            rsp_valid <= 1'b1;
                        end
                    end
                    if (fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_bit && last_word) begin
                            shift <= 1'b0;
                            tdi   <= 1'b0;
                        end else if (last_bit) begin
                            word_cnt <= word_cnt + 16'd1;
                            tdi      <= wdata_q[15];
                            tx_sr    <= {wdata_q[14:0], 1'b0};
                        end else begin
                            tdi   <= tx_sr[15];
                            tx_sr <= {tx_sr[14:0], 1'b0};
                        end
                    end
                end
                EXIT: if (fall && pending) exit_done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
